// File: rtl/xor_bind_checker.sv
// rtl/xor_bind_checker.sv - reference a^b pipeline with per-channel compare and error bookkeeping
module xor_bind_checker #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 1,
    parameter int LATENCY  = 1,
    parameter int CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [CHANNELS*WIDTH-1:0]   a,
    input  logic [CHANNELS*WIDTH-1:0]   b,
    input  logic                        obs_valid,
    input  logic [CHANNELS*WIDTH-1:0]   obs_c,
    input  logic                        clear,
    output logic                        exp_valid,
    output logic [CHANNELS*WIDTH-1:0]   exp_c,
    output logic [CHANNELS-1:0]         mismatch,
    output logic                        orphan,
    output logic                        err_sticky,
    output logic [CNT_W-1:0]            err_count
);

    localparam int DW = CHANNELS * WIDTH;

    logic [LATENCY-1:0] vld_pipe;
    logic [DW-1:0]      dat_pipe [LATENCY];

    // Data stages only load behind a valid, so a bubble leaves the last result on exp_c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= in_valid;
            if (in_valid) begin
                dat_pipe[0] <= a ^ b;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) begin
                    dat_pipe[i] <= dat_pipe[i-1];
                end
            end
        end
    end

    assign exp_valid = vld_pipe[LATENCY-1];
    assign exp_c     = dat_pipe[LATENCY-1];

    logic [CHANNELS-1:0] cmp_mismatch;
    logic                cmp_orphan;
    logic                err_cycle;

    always_comb begin
        cmp_mismatch = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cmp_mismatch[k] = exp_valid && obs_valid &&
                              (obs_c[k*WIDTH +: WIDTH] != exp_c[k*WIDTH +: WIDTH]);
        end
        cmp_orphan = obs_valid && !exp_valid;
        err_cycle  = (|cmp_mismatch) || cmp_orphan;
    end

    // Pulses always fire; clear only suppresses the bookkeeping of a coincident error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch   <= '0;
            orphan     <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            mismatch <= cmp_mismatch;
            orphan   <= cmp_orphan;
            if (clear) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
            end else if (err_cycle) begin
                err_sticky <= 1'b1;
                if (err_count != {CNT_W{1'b1}}) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_bind_checker.sv
// tb/tb_xor_bind_checker.sv - directed vector bench for xor_bind_checker (4-bit x 2 channels, latency 3, 2-bit counter)
module tb_xor_bind_checker;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 2;
    localparam int LATENCY  = 3;
    localparam int CNT_W    = 2;
    localparam int DW       = WIDTH * CHANNELS;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DW-1:0]     a;
    logic [DW-1:0]     b;
    logic              obs_valid;
    logic [DW-1:0]     obs_c;
    logic              clear;
    logic              exp_valid;
    logic [DW-1:0]     exp_c;
    logic [CHANNELS-1:0] mismatch;
    logic              orphan;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xor_bind_checker #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .LATENCY(LATENCY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .obs_valid(obs_valid), .obs_c(obs_c), .clear(clear),
        .exp_valid(exp_valid), .exp_c(exp_c), .mismatch(mismatch),
        .orphan(orphan), .err_sticky(err_sticky), .err_count(err_count)
    );

    typedef struct {
        logic        iv;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ov;
        logic [7:0]  oc;
        logic        clr;
        logic        ev;
        logic [7:0]  ec;
        logic [1:0]  mm;
        logic        orp;
        logic        st;
        logic [1:0]  cnt;
    } vec_t;

    vec_t vecs [32];

    function automatic vec_t mk(input logic iv, input logic [7:0] va, input logic [7:0] vb,
                                input logic ov, input logic [7:0] oc, input logic clr,
                                input logic ev, input logic [7:0] ec, input logic [1:0] mm,
                                input logic orp, input logic st, input logic [1:0] cnt);
        vec_t v;
        v.iv = iv; v.a = va; v.b = vb; v.ov = ov; v.oc = oc; v.clr = clr;
        v.ev = ev; v.ec = ec; v.mm = mm; v.orp = orp; v.st = st; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [7:0] ec,
                             input logic [1:0] mm, input logic orp, input logic st,
                             input logic [1:0] cnt);
        check({tag, " exp_valid"},  64'(exp_valid),  64'(ev));
        check({tag, " exp_c"},      64'(exp_c),      64'(ec));
        check({tag, " mismatch"},   64'(mismatch),   64'(mm));
        check({tag, " orphan"},     64'(orphan),     64'(orp));
        check({tag, " err_sticky"}, 64'(err_sticky), 64'(st));
        check({tag, " err_count"},  64'(err_count),  64'(cnt));
    endtask

    task automatic drive(input logic iv, input logic [7:0] va, input logic [7:0] vb,
                         input logic ov, input logic [7:0] oc, input logic clr);
        in_valid = iv; a = va; b = vb; obs_valid = ov; obs_c = oc; clear = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                iv  a      b      ov  oc     clr   ev  ec     mm     orp st  cnt
        vecs[0]  = mk(1, 8'h5A, 8'h0F, 0, 8'h00, 0,   0, 8'h00, 2'b00, 0, 0, 2'd0);
        vecs[1]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   0, 8'h00, 2'b00, 0, 0, 2'd0);
        vecs[2]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   1, 8'h55, 2'b00, 0, 0, 2'd0);
        vecs[3]  = mk(0, 8'h00, 8'h00, 1, 8'h45, 0,   0, 8'h55, 2'b10, 0, 1, 2'd1);
        vecs[4]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   0, 8'h55, 2'b00, 0, 1, 2'd1);
        vecs[5]  = mk(1, 8'h5A, 8'h0F, 0, 8'h00, 0,   0, 8'h55, 2'b00, 0, 1, 2'd1);
        vecs[6]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   0, 8'h55, 2'b00, 0, 1, 2'd1);
        vecs[7]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   1, 8'h55, 2'b00, 0, 1, 2'd1);
        vecs[8]  = mk(0, 8'h00, 8'h00, 1, 8'h55, 0,   0, 8'h55, 2'b00, 0, 1, 2'd1);
        vecs[9]  = mk(0, 8'h00, 8'h00, 1, 8'h00, 0,   0, 8'h55, 2'b00, 1, 1, 2'd2);
        vecs[10] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   0, 8'h55, 2'b00, 0, 1, 2'd2);
        vecs[11] = mk(1, 8'h12, 8'h34, 0, 8'h00, 0,   0, 8'h55, 2'b00, 0, 1, 2'd2);
        vecs[12] = mk(1, 8'hFF, 8'h0F, 0, 8'h00, 0,   0, 8'h55, 2'b00, 0, 1, 2'd2);
        vecs[13] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   1, 8'h26, 2'b00, 0, 1, 2'd2);
        vecs[14] = mk(1, 8'hA5, 8'hA5, 1, 8'h26, 0,   1, 8'hF0, 2'b00, 0, 1, 2'd2);
        vecs[15] = mk(0, 8'h00, 8'h00, 1, 8'h0F, 0,   0, 8'hF0, 2'b11, 0, 1, 2'd3);
        vecs[16] = mk(0, 8'h00, 8'h00, 1, 8'h00, 0,   1, 8'h00, 2'b00, 1, 1, 2'd3);
        vecs[17] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   0, 8'h00, 2'b00, 0, 1, 2'd3);
        vecs[18] = mk(0, 8'h00, 8'h00, 0, 8'h00, 1,   0, 8'h00, 2'b00, 0, 0, 2'd0);
        vecs[19] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   0, 8'h00, 2'b00, 0, 0, 2'd0);
        vecs[20] = mk(0, 8'h00, 8'h00, 1, 8'h00, 0,   0, 8'h00, 2'b00, 1, 1, 2'd1);
        vecs[21] = mk(0, 8'h00, 8'h00, 1, 8'h00, 0,   0, 8'h00, 2'b00, 1, 1, 2'd2);
        vecs[22] = mk(0, 8'h00, 8'h00, 1, 8'h00, 0,   0, 8'h00, 2'b00, 1, 1, 2'd3);
        vecs[23] = mk(0, 8'h00, 8'h00, 1, 8'h00, 0,   0, 8'h00, 2'b00, 1, 1, 2'd3);
        vecs[24] = mk(0, 8'h00, 8'h00, 1, 8'h00, 0,   0, 8'h00, 2'b00, 1, 1, 2'd3);
        vecs[25] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   0, 8'h00, 2'b00, 0, 1, 2'd3);
        vecs[26] = mk(1, 8'h0F, 8'hF0, 0, 8'h00, 1,   0, 8'h00, 2'b00, 0, 0, 2'd0);
        vecs[27] = mk(1, 8'h11, 8'h22, 1, 8'h00, 0,   0, 8'h00, 2'b00, 1, 1, 2'd1);
        vecs[28] = mk(0, 8'h00, 8'h00, 1, 8'h00, 0,   1, 8'hFF, 2'b00, 1, 1, 2'd2);
        vecs[29] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   1, 8'h33, 2'b00, 0, 1, 2'd2);
        vecs[30] = mk(0, 8'h00, 8'h00, 1, 8'h30, 1,   0, 8'h33, 2'b01, 0, 0, 2'd0);
        vecs[31] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0,   0, 8'h33, 2'b00, 0, 0, 2'd0);

        rst = 1'b1;
        drive(0, 8'h00, 8'h00, 0, 8'h00, 0);
        #2;
        check_all("reset", 0, 8'h00, 2'b00, 0, 0, 2'd0);
        tick();
        tick();
        #2 rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            drive(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].ov, vecs[i].oc, vecs[i].clr);
            tick();
            check_all($sformatf("row%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].mm,
                      vecs[i].orp, vecs[i].st, vecs[i].cnt);
        end

        // Asynchronous reset with two samples in flight and error state set.
        drive(1, 8'h11, 8'h22, 1, 8'h00, 0);
        tick();
        check_all("pre_rst1", 0, 8'h33, 2'b00, 1, 1, 2'd1);
        drive(1, 8'h33, 8'h44, 1, 8'h00, 0);
        tick();
        check_all("pre_rst2", 0, 8'h33, 2'b00, 1, 1, 2'd2);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 0, 8'h00, 2'b00, 0, 0, 2'd0);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("flush%0d exp_valid", i), 64'(exp_valid), 64'(0));
        end

        drive(1, 8'h0F, 8'h05, 0, 8'h00, 0);
        tick();
        drive(0, 8'h00, 8'h00, 0, 8'h00, 0);
        check("post_rst e1 exp_valid", 64'(exp_valid), 64'(0));
        tick();
        check("post_rst e2 exp_valid", 64'(exp_valid), 64'(0));
        tick();
        check("post_rst e3 exp_valid", 64'(exp_valid), 64'(1));
        check("post_rst e3 exp_c", 64'(exp_c), 64'h0A);
        tick();
        check("post_rst e4 exp_valid", 64'(exp_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
